// File: rtl/inputs_mem_pkg.sv
// Shared types and constants for the input-sample memory arbiter.
// Requester ids are one bit: 0 is the host/loader, 1 is the compute datapath.
package inputs_mem_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned ADDR_W    = 7;
  localparam int unsigned MAX_BURST = 8;
  localparam int unsigned RD_LAT    = 1;

  typedef logic req_id_t;

  typedef enum logic {
    StIdle,
    StOwn
  } arb_state_e;

endpackage

// File: rtl/rd_tag_pipe.sv
// Fixed-depth shift register of {valid, id} read tags; lines up each issued read
// with the memory's read latency so the result can be steered to its requester.
module rd_tag_pipe
  import inputs_mem_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    in_valid_i,
  input  req_id_t in_id_i,
  output logic    out_valid_o,
  output req_id_t out_id_o
);

  logic [Depth-1:0] valid_q, valid_d;
  logic [Depth-1:0] id_q, id_d;

  always_comb begin
    valid_d    = valid_q;
    id_d       = id_q;
    valid_d[0] = in_valid_i;
    id_d[0]    = in_id_i;
    for (int unsigned i = 1; i < Depth; i++) begin
      valid_d[i] = valid_q[i-1];
      id_d[i]    = id_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      id_q    <= '0;
    end else begin
      valid_q <= valid_d;
      id_q    <= id_d;
    end
  end

  assign out_valid_o = valid_q[Depth-1];
  assign out_id_o    = id_q[Depth-1];

endmodule

// File: rtl/inputs_mem_arbiter.sv
// Round-robin, burst-bounded arbiter sharing the single-port input-sample memory
// between two requesters; memory strobes are registered and read data is routed back.
module inputs_mem_arbiter
  import inputs_mem_pkg::*;
#(
  parameter int unsigned DATA_W    = inputs_mem_pkg::DATA_W,
  parameter int unsigned ADDR_W    = inputs_mem_pkg::ADDR_W,
  parameter int unsigned MAX_BURST = inputs_mem_pkg::MAX_BURST,
  parameter int unsigned RD_LAT    = inputs_mem_pkg::RD_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_out
);

  localparam int unsigned CntW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MAX_BURST - 1);

  arb_state_e        state_q, state_d;
  req_id_t           owner_q, owner_d;
  req_id_t           last_owner_q, last_owner_d;
  logic [CntW-1:0]   beat_cnt_q, beat_cnt_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [DATA_W-1:0] mem_in_q, mem_in_d;
  logic              mem_write_q, mem_write_d;
  logic              mem_read_q, mem_read_d;
  req_id_t           rd_id_q, rd_id_d;

  logic              req_own, req_oth, we_own, accept, release_own;
  logic [ADDR_W-1:0] addr_own;
  logic [DATA_W-1:0] wdata_own;

  always_comb begin
    req_own   = owner_q ? req1 : req0;
    req_oth   = owner_q ? req0 : req1;
    we_own    = owner_q ? we1 : we0;
    addr_own  = owner_q ? addr1 : addr0;
    wdata_own = owner_q ? wdata1 : wdata0;
    accept    = (state_q == StOwn) && req_own;
    // Burst limit only forces a handover when the other side is actually waiting.
    release_own = (state_q == StOwn) &&
                  (!req_own || (accept && (beat_cnt_q == CntLast) && req_oth));
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_owner_d  = last_owner_q;
    beat_cnt_d    = beat_cnt_q;
    mem_address_d = mem_address_q;
    mem_in_d      = mem_in_q;
    mem_write_d   = 1'b0;
    mem_read_d    = 1'b0;
    rd_id_d       = rd_id_q;

    case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          state_d      = StOwn;
          owner_d      = (req0 && req1) ? ~last_owner_q : req_id_t'(req1);
          last_owner_d = owner_d;
          beat_cnt_d   = '0;
        end
      end
      StOwn: begin
        if (accept) begin
          mem_address_d = addr_own;
          mem_in_d      = wdata_own;
          mem_write_d   = we_own;
          mem_read_d    = ~we_own;
          rd_id_d       = owner_q;
          beat_cnt_d    = (beat_cnt_q == CntLast) ? '0 : beat_cnt_q + 1'b1;
        end
        if (release_own) begin
          if (req_oth) begin
            owner_d      = ~owner_q;
            last_owner_d = ~owner_q;
            beat_cnt_d   = '0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    gnt0_d = (state_d == StOwn) && (owner_d == 1'b0);
    gnt1_d = (state_d == StOwn) && (owner_d == 1'b1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      owner_q       <= 1'b0;
      last_owner_q  <= 1'b1;
      beat_cnt_q    <= '0;
      gnt0_q        <= 1'b0;
      gnt1_q        <= 1'b0;
      mem_address_q <= '0;
      mem_in_q      <= '0;
      mem_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      rd_id_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_owner_q  <= last_owner_d;
      beat_cnt_q    <= beat_cnt_d;
      gnt0_q        <= gnt0_d;
      gnt1_q        <= gnt1_d;
      mem_address_q <= mem_address_d;
      mem_in_q      <= mem_in_d;
      mem_write_q   <= mem_write_d;
      mem_read_q    <= mem_read_d;
      rd_id_q       <= rd_id_d;
    end
  end

  logic    tag_valid;
  req_id_t tag_id;

  // The tag enters while mem_read is high, so it exits alongside valid mem_out.
  rd_tag_pipe #(
    .Depth(RD_LAT)
  ) u_rd_tag_pipe (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (mem_read_q),
    .in_id_i    (rd_id_q),
    .out_valid_o(tag_valid),
    .out_id_o   (tag_id)
  );

  assign gnt0        = gnt0_q;
  assign gnt1        = gnt1_q;
  assign mem_address = mem_address_q;
  assign mem_in      = mem_in_q;
  assign mem_write   = mem_write_q;
  assign mem_read    = mem_read_q;
  assign rvalid0     = tag_valid && (tag_id == 1'b0);
  assign rvalid1     = tag_valid && (tag_id == 1'b1);
  assign rdata       = tag_valid ? mem_out : '0;

`ifndef SYNTHESIS
  gnt_onehot_a : assert property (@(posedge clk) disable iff (rst) !(gnt0_q && gnt1_q));
  strobe_excl_a : assert property (@(posedge clk) disable iff (rst) !(mem_write_q && mem_read_q));
`endif

endmodule
